// File: rtl/bk_sub16_pipe_if.sv
// Handshake bundle for the 16-bit Brent-Kung subtractor pipe.
// The master drives operands and result acceptance.
// The slave (the subtractor) returns the difference and compare flags.
interface bk_sub16_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] diff;
    logic        zero;
    logic        ltu;
    logic        lts;
    logic        ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, zero, ltu, lts, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, zero, ltu, lts, ovf
    );
endinterface

// File: rtl/bk_sub16_pipe.sv
// Two-stage pipelined 16-bit subtractor, a - b = a + ~b + 1.
// The borrow network is a Brent-Kung prefix tree.
// Stage 1 forms the bit terms and the span-2/span-4 up-sweep groups.
// Stage 2 finishes the up-sweep, runs the down-sweep, and registers the result and flags.
module bk_sub16_pipe (
    input  logic            clk,
    input  logic            rst_n,
    bk_sub16_pipe_if.slave  bus
);

    // Prefix operator on {G,P} pairs: hi group sits above lo group.
    function automatic logic [1:0] bk_op(input logic [1:0] hi, input logic [1:0] lo);
        bk_op = {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
    endfunction

    // Handshake
    logic s1_valid_r;
    logic out_valid_r;
    logic s2_adv_s;
    logic in_ready_s;

    // Stage 1 combinational terms
    logic [15:0]      p_s;
    logic [15:0]      g_s;
    logic [7:0][1:0]  l1_s;
    logic [3:0][1:0]  l2_s;

    // Stage 1 registers
    logic [15:0]      p_r;
    logic [15:0]      g_r;
    logic [7:0][1:0]  l1_r;
    logic [3:0][1:0]  l2_r;
    logic             a15_r;
    logic             b15_r;

    // Stage 2 combinational terms: pfx_s[i] is the {G,P} group covering bits i..0 (carry-in folded)
    logic [15:0][1:0] pfx_s;
    logic [15:0]      c_s;
    logic [15:0]      sum_s;
    logic             cout_s;
    logic             ovf_s;

    // Stage 2 / output registers
    logic [16:0]      diff_r;
    logic             zero_r;
    logic             ltu_r;
    logic             lts_r;
    logic             ovf_r;

    assign s2_adv_s   = ~out_valid_r | bus.out_ready;
    assign in_ready_s = ~s1_valid_r | s2_adv_s;

    // Bit terms with the carry-in folded into bit 0, then up-sweep spans 2 and 4.
    always_comb begin
        p_s  = bus.a ^ ~bus.b;
        g_s  = (bus.a & ~bus.b) | {15'h0000, (bus.a[0] ^ ~bus.b[0])};
        l1_s = 16'h0000;
        l2_s = 8'h00;
        for (int k = 0; k < 8; k++) begin
            l1_s[k] = bk_op({g_s[2*k+1], p_s[2*k+1]}, {g_s[2*k], p_s[2*k]});
        end
        for (int k = 0; k < 4; k++) begin
            l2_s[k] = bk_op(l1_s[2*k+1], l1_s[2*k]);
        end
    end

    // Up-sweep spans 8 and 16, then down-sweep for the remaining prefixes, then the sum XOR.
    always_comb begin
        pfx_s     = 32'h0000_0000;
        pfx_s[0]  = {g_r[0], p_r[0]};
        pfx_s[1]  = l1_r[0];
        pfx_s[3]  = l2_r[0];
        pfx_s[7]  = bk_op(l2_r[1], l2_r[0]);
        pfx_s[15] = bk_op(bk_op(l2_r[3], l2_r[2]), pfx_s[7]);
        pfx_s[11] = bk_op(l2_r[2], pfx_s[7]);
        pfx_s[5]  = bk_op(l1_r[2], pfx_s[3]);
        pfx_s[9]  = bk_op(l1_r[4], pfx_s[7]);
        pfx_s[13] = bk_op(l1_r[6], pfx_s[11]);
        for (int i = 2; i < 16; i += 2) begin
            pfx_s[i] = bk_op({g_r[i], p_r[i]}, pfx_s[i-1]);
        end
        c_s    = 16'h0000;
        c_s[0] = 1'b1;
        for (int i = 1; i < 16; i++) begin
            c_s[i] = pfx_s[i-1][1];
        end
        sum_s  = p_r ^ c_s;
        cout_s = pfx_s[15][1];
        ovf_s  = (a15_r ^ b15_r) & (sum_s[15] ^ a15_r);
    end

    // Stage 1: accept operands whenever the stage can move; bubbles clear valid but keep data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            p_r        <= 16'h0000;
            g_r        <= 16'h0000;
            l1_r       <= 16'h0000;
            l2_r       <= 8'h00;
            a15_r      <= 1'b0;
            b15_r      <= 1'b0;
        end else if (in_ready_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                p_r   <= p_s;
                g_r   <= g_s;
                l1_r  <= l1_s;
                l2_r  <= l2_s;
                a15_r <= bus.a[15];
                b15_r <= bus.b[15];
            end
        end
    end

    // Stage 2: register difference and flags; hold everything while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            diff_r      <= 17'h00000;
            zero_r      <= 1'b0;
            ltu_r       <= 1'b0;
            lts_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (s2_adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                diff_r <= {~cout_s, sum_s};
                zero_r <= (sum_s == 16'h0000);
                ltu_r  <= ~cout_s;
                lts_r  <= sum_s[15] ^ ovf_s;
                ovf_r  <= ovf_s;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.diff      = diff_r;
    assign bus.zero      = zero_r;
    assign bus.ltu       = ltu_r;
    assign bus.lts       = lts_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_bk_sub16_pipe.sv
// Self-checking bench for bk_sub16_pipe.
// Directed vectors check the arithmetic and flags.
// A scoreboard checks order, stall stability and in_ready on every cycle.
module tb_bk_sub16_pipe;

    typedef logic [20:0] res_t;   // {diff[16:0], zero, ltu, lts, ovf}

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        res_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;
    int n_push   = 0;
    int n_pop    = 0;

    res_t exp_q[$];
    logic prev_stall = 1'b0;
    res_t prev_res;

    // Free-running clock
    always #5 clk = ~clk;

    bk_sub16_pipe_if bus();

    bk_sub16_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Single comparison point for every check in the bench.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference difference and flags from plain integer arithmetic.
    function automatic res_t ref_sub(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] d;
        int          sa;
        int          sb;
        int          sd;
        logic        ov;
        d  = {1'b0, a} - {1'b0, b};
        sa = int'($signed(a));
        sb = int'($signed(b));
        sd = sa - sb;
        ov = (sd > 32767) || (sd < -32768);
        return {d, (d[15:0] == 16'h0000), (a < b), (sa < sb), ov};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard sampled mid-cycle, on the falling edge.
    always @(negedge clk) begin
        res_t cur;
        cur = {bus.diff, bus.zero, bus.ltu, bus.lts, bus.ovf};
        if (rst_n !== 1'b1) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check_eq("in_ready", {31'h0, bus.in_ready},
                     {31'h0, !(exp_q.size() == 2 && !bus.out_ready)});
            if (prev_stall) begin
                check_eq("stall_valid", {31'h0, bus.out_valid}, 32'h1);
                check_eq("stall_hold", {11'h0, cur}, {11'h0, prev_res});
            end
            if (bus.out_valid && bus.out_ready) begin
                check_eq("q_nonempty", {31'h0, exp_q.size() > 0}, 32'h1);
                if (exp_q.size() > 0) begin
                    check_eq("result", {11'h0, cur}, {11'h0, exp_q.pop_front()});
                end
                n_pop++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_sub(bus.a, bus.b));
                n_push++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_res   = cur;
        end
    end

    vec_t vecs[6];
    int   base_pop;

    // Directed stimulus
    initial begin
        // {diff, zero, ltu, lts, ovf}, worked out by hand
        vecs[0] = '{16'h1234, 16'h0234, {17'h01000, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{16'h0005, 16'h0005, {17'h00000, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[2] = '{16'h0000, 16'h0001, {17'h1FFFF, 1'b0, 1'b1, 1'b1, 1'b0}};
        vecs[3] = '{16'h8000, 16'h0001, {17'h07FFF, 1'b0, 1'b0, 1'b1, 1'b1}};
        // 0x7FFF + 0x0000 + 1 wraps to 0x8000 with borrow; 32767 - (-1) overflows
        vecs[4] = '{16'h7FFF, 16'hFFFF, {17'h18000, 1'b0, 1'b1, 1'b0, 1'b1}};
        vecs[5] = '{16'hFFFF, 16'h0001, {17'h0FFFE, 1'b0, 1'b0, 1'b1, 1'b0}};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 16'hAAAA;
        bus.b         = 16'h5555;
        bus.out_ready = 1'b1;

        // Reset held two cycles with in_valid high
        for (int i = 0; i < 2; i++) begin
            cyc();
            check_eq("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
            check_eq("rst_diff", {15'h0, bus.diff}, 32'h0);
        end
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        check_eq("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        cyc();

        // Directed values, one at a time
        foreach (vecs[i]) begin
            bus.a        = vecs[i].a;
            bus.b        = vecs[i].b;
            bus.in_valid = 1'b1;
            cyc();
            bus.in_valid = 1'b0;
            check_eq("lat_early", {31'h0, bus.out_valid}, 32'h0);
            cyc();
            check_eq("lat_valid", {31'h0, bus.out_valid}, 32'h1);
            check_eq($sformatf("vec%0d", i),
                     {11'h0, bus.diff, bus.zero, bus.ltu, bus.lts, bus.ovf},
                     {11'h0, vecs[i].exp});
            cyc();
        end

        // Back-to-back streaming with the consumer always ready
        base_pop = n_pop;
        for (int i = 0; i < 1000; i++) begin
            bus.a        = 16'($urandom_range(0, 65535));
            bus.b        = 16'($urandom_range(0, 65535));
            bus.in_valid = 1'b1;
            cyc();
            if (i >= 1) begin
                check_eq("stream_valid", {31'h0, bus.out_valid}, 32'h1);
            end
        end
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        check_eq("stream_count", n_pop - base_pop, 32'd1000);
        check_eq("stream_drain", exp_q.size(), 32'd0);

        // Fill both stages, then drain and load in the same cycle
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a = 16'h0100; bus.b = 16'h0001;
        cyc();
        bus.a = 16'h0200; bus.b = 16'h0002;
        cyc();
        bus.a = 16'h0300; bus.b = 16'h0003;
        check_eq("cap_full_ready", {31'h0, bus.in_ready}, 32'h0);
        check_eq("cap_full_valid", {31'h0, bus.out_valid}, 32'h1);
        check_eq("cap_hold_diff", {15'h0, bus.diff}, 32'h000FF);
        cyc();
        check_eq("cap_stall_diff", {15'h0, bus.diff}, 32'h000FF);
        bus.out_ready = 1'b1;
        #1;
        check_eq("full_drain_ready", {31'h0, bus.in_ready}, 32'h1);
        cyc();
        bus.in_valid = 1'b0;
        repeat (3) cyc();
        check_eq("cap_drain", exp_q.size(), 32'd0);

        // Reset with both stages occupied
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a = 16'h1111; bus.b = 16'h0001;
        cyc();
        bus.a = 16'h2222; bus.b = 16'h0002;
        cyc();
        check_eq("mid_full_ready", {31'h0, bus.in_ready}, 32'h0);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        cyc();
        check_eq("mid_rst_valid", {31'h0, bus.out_valid}, 32'h0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        bus.a = 16'h0010; bus.b = 16'h0001;
        bus.in_valid  = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        check_eq("mid_post_early", {31'h0, bus.out_valid}, 32'h0);
        cyc();
        check_eq("mid_post_valid", {31'h0, bus.out_valid}, 32'h1);
        check_eq("mid_post_res", {11'h0, bus.diff, bus.zero, bus.ltu, bus.lts, bus.ovf},
                 {11'h0, 17'h0000F, 1'b0, 1'b0, 1'b0, 1'b0});
        cyc();

        // Random backpressure at roughly 30 % ready
        for (int i = 0; i < 800; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.a         = 16'($urandom_range(0, 65535));
            bus.b         = 16'($urandom_range(0, 65535));
            bus.out_ready = ($urandom_range(0, 9) < 3);
            cyc();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) cyc();
        check_eq("bp_drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
